// File: rtl/scope_trigger_capture.sv
// Trigger and capture stage for the VGA oscilloscope.
// The block watches the sample stream and fires on a level/slope crossing, or on an
// auto timeout. It keeps DEPTH samples in a circular RAM, with PRETRIG of them taken
// before the trigger. The finished record is then frozen so the display stage can
// read it by logical index, where index 0 is the oldest sample.
//
// Handshake: sample_in/sample_valid is a valid-only stream with no ready. A sample is
// consumed on every cycle that sample_valid is high while the state is PRE, ARMED or
// POST. It is dropped in DONE and on a rearm or reset cycle. Nothing pushes back on
// the producer.
module scope_trigger_capture #(
  parameter int DW           = 16,
  parameter int DEPTH        = 1280,
  parameter int AW           = 11,
  parameter int PRETRIG      = 128,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic          trig_auto,
  input  logic          rearm,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          capture_done,
  output logic          forced,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    PRE   = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } captureState;

  // Number of samples written after the trigger sample itself.
  localparam int POST_LEN = DEPTH - PRETRIG - 1;
  localparam int TW       = $clog2(AUTO_TIMEOUT + 1);

  localparam logic [AW-1:0] PRE_LAST     = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST    = AW'(POST_LEN - 1);
  localparam logic [AW-1:0] LAST_ADDR    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRETRIG_A    = AW'(PRETRIG);
  localparam logic [AW-1:0] WRAP_ADJ     = AW'(DEPTH - PRETRIG);
  localparam logic [AW:0]   DEPTH_X      = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(AUTO_TIMEOUT - 1);

  captureState   state;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] cnt;
  logic [AW-1:0] startPtr;
  logic [AW-1:0] trigPtr;
  logic [TW-1:0] timeoutCnt;
  logic [DW-1:0] prevSample;
  logic          prevValid;

  logic [DW-1:0] mem [DEPTH];

  logic          writeEn;
  logic [AW-1:0] wrPtrNext;
  logic          risingHit;
  logic          fallingHit;
  logic          levelHit;
  logic          timeoutHit;
  logic [AW-1:0] startFromWr;
  logic [AW:0]   physSum;
  logic [AW:0]   physWrapped;
  logic [AW-1:0] physAddr;
  logic          rdInRange;

  assign state_o = state;

  // Write enable, pointer wrap, trigger detection and the read address mapping.
  always_comb begin
    writeEn     = sample_valid && !reset && !rearm && (state != DONE);
    wrPtrNext   = (wrPtr == LAST_ADDR) ? '0 : wrPtr + 1'b1;

    // The comparisons are unsigned because the samples are offset-binary.
    risingHit   = prevValid && (prevSample <  trig_level) && (sample_in >= trig_level);
    fallingHit  = prevValid && (prevSample >= trig_level) && (sample_in <  trig_level);
    levelHit    = trig_slope ? fallingHit : risingHit;
    timeoutHit  = trig_auto && (timeoutCnt == TIMEOUT_LAST);

    // The oldest sample sits PRETRIG slots before the trigger address. When the
    // trigger address is below PRETRIG, wrap forward instead of going negative.
    startFromWr = (wrPtr >= PRETRIG_A) ? (wrPtr - PRETRIG_A) : (wrPtr + WRAP_ADJ);

    // Map the logical index to a physical address with a single conditional subtract.
    // The sum is always below 2*DEPTH.
    physSum     = {1'b0, startPtr} + {1'b0, rd_addr};
    physWrapped = physSum - DEPTH_X;
    physAddr    = (physSum >= DEPTH_X) ? physWrapped[AW-1:0] : physSum[AW-1:0];
    rdInRange   = ({1'b0, rd_addr} < DEPTH_X);
  end

  // Capture FSM: pointers, counters, trigger bookkeeping and the status flags.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= PRE;
      wrPtr        <= '0;
      cnt          <= '0;
      startPtr     <= '0;
      trigPtr      <= '0;
      timeoutCnt   <= '0;
      prevSample   <= '0;
      prevValid    <= 1'b0;
      capture_done <= 1'b0;
      forced       <= 1'b0;
    end else if (rearm) begin
      // Abandon whatever was captured. wrPtr keeps running so the RAM stays circular.
      state        <= PRE;
      cnt          <= '0;
      prevValid    <= 1'b0;
      capture_done <= 1'b0;
      forced       <= 1'b0;
    end else begin
      case (state)
        PRE: begin
          if (sample_valid) begin
            wrPtr      <= wrPtrNext;
            prevSample <= sample_in;
            prevValid  <= 1'b1;
            if (cnt == PRE_LAST) begin
              state      <= ARMED;
              cnt        <= '0;
              timeoutCnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ARMED: begin
          if (sample_valid) begin
            wrPtr      <= wrPtrNext;
            prevSample <= sample_in;
            prevValid  <= 1'b1;
            if (levelHit || timeoutHit) begin
              // The sample being written now is the trigger sample.
              trigPtr  <= wrPtr;
              startPtr <= startFromWr;
              forced   <= !levelHit;
              cnt      <= '0;
              if (POST_LEN == 0) begin
                state        <= DONE;
                capture_done <= 1'b1;
              end else begin
                state <= POST;
              end
            end else begin
              timeoutCnt <= timeoutCnt + 1'b1;
            end
          end
        end

        POST: begin
          if (sample_valid) begin
            wrPtr      <= wrPtrNext;
            prevSample <= sample_in;
            prevValid  <= 1'b1;
            if (cnt == POST_LAST) begin
              state        <= DONE;
              capture_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        DONE: begin
          // The record is frozen. There is no history for a slope check until the
          // block is rearmed.
          prevValid <= 1'b0;
        end
      endcase
    end
  end

  // Sample RAM write port. There is no reset here, so the array maps onto a block RAM.
  always_ff @(posedge CLOCK_50) begin
    if (writeEn) begin
      mem[wrPtr] <= sample_in;
    end
  end

  // Registered read port: one cycle of latency, and zero for an out-of-range index.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_data <= '0;
    end else if (!rdInRange) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[physAddr];
    end
  end

endmodule
